// File: rtl/mmio_pkg.sv
// Shared widths, register map and FSM encoding for the MMIO initiator.
package mmio_pkg;

  localparam int MMIO_ADDR_W = 8;
  localparam int MMIO_DATA_W = 32;

  localparam logic [MMIO_DATA_W-1:0] ID_VALUE = 32'hA1C0_0001;

  // UART responder register map
  localparam logic [MMIO_ADDR_W-1:0] REG_ID     = 8'h00;
  localparam logic [MMIO_ADDR_W-1:0] REG_CTRL   = 8'h04;
  localparam logic [MMIO_ADDR_W-1:0] REG_STATUS = 8'h08;
  localparam logic [MMIO_ADDR_W-1:0] REG_TXDATA = 8'h0C;
  localparam logic [MMIO_ADDR_W-1:0] REG_RXDATA = 8'h10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

endpackage

// File: rtl/mmio_wdog.sv
// Bus watchdog: counts stalled REQ cycles, flags the cycle that reaches LIMIT.
module mmio_wdog #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (clear)  r_cnt <= '0;
    else if (enable) r_cnt <= r_cnt + 8'd1;
  end

  // Combinational so the abort lands in the same cycle the count would hit LIMIT.
  assign expired = enable && (r_cnt == LAST);

endmodule

// File: rtl/mmio_initiator.sv
// Single-outstanding MMIO bus initiator (cmd -> bus strobe -> rsp).
// Optional bus timeout enabled by defining MMIO_INITIATOR_TIMEOUT_EN.
module mmio_initiator
  import mmio_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [MMIO_ADDR_W-1:0] cmd_addr,
  input  logic [MMIO_DATA_W-1:0] cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [MMIO_DATA_W-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic [MMIO_ADDR_W-1:0] addr,
  output logic [MMIO_DATA_W-1:0] wdata,
  output logic                   we,
  output logic                   re,
  input  logic [MMIO_DATA_W-1:0] rdata,
  input  logic                   ready
);

  state_t                 r_state, w_state_nxt;
  logic [MMIO_ADDR_W-1:0] r_addr;
  logic [MMIO_DATA_W-1:0] r_wdata;
  logic                   r_we, r_re;
  logic [MMIO_DATA_W-1:0] r_rsp_rdata;

  logic w_accept, w_in_req, w_done, w_expired;

  assign w_accept = (r_state == IDLE) && cmd_valid;
  assign w_in_req = (r_state == REQ);
  assign w_done   = w_in_req && ready;

`ifdef MMIO_INITIATOR_TIMEOUT_EN
  logic r_rsp_err;

  mmio_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_accept),
    .enable  (w_in_req && !ready),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_rsp_err <= 1'b0;
    else if (w_done)    r_rsp_err <= 1'b0;
    else if (w_expired) r_rsp_err <= 1'b1;
  end

  assign rsp_err = r_rsp_err;
`else
  assign w_expired = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (cmd_valid)          w_state_nxt = REQ;
      REQ:     if (ready || w_expired) w_state_nxt = RSP;
      RSP:     if (rsp_ready)          w_state_nxt = IDLE;
      default:                         w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Bus side: addr/wdata only change on acceptance so they hold outside REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= cmd_addr;
      r_wdata <= cmd_write ? cmd_wdata : '0;
      r_we    <= cmd_write;
      r_re    <= !cmd_write;
    end else if (w_done || w_expired) begin
      r_we    <= 1'b0;
      r_re    <= 1'b0;
    end
  end

  // Ready wins over timeout: w_done is tested first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_rsp_rdata <= '0;
    else if (w_done)    r_rsp_rdata <= r_re ? rdata : '0;
    else if (w_expired) r_rsp_rdata <= '0;
  end

  assign cmd_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RSP);
  assign rsp_rdata = r_rsp_rdata;
  assign addr      = r_addr;
  assign wdata     = r_wdata;
  assign we        = r_we;
  assign re        = r_re;

endmodule

// File: doc/mmio_initiator.md
MMIO_INITIATOR -- requirements
Module: mmio_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: number of REQ cycles without bus ready before abort; legal range 2..255.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, as the ports clk and rst_n below.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_addr  input  8  target register address.
REQ-009 cmd_wdata  input  32  write data; ignored for reads.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-012 rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-013 rsp_err  output  1  transaction timed out.
REQ-014 addr  output  8  MMIO bus address.
REQ-015 wdata  output  32  MMIO bus write data.
REQ-016 we  output  1  MMIO bus write strobe.
REQ-017 re  output  1  MMIO bus read strobe.
REQ-018 rdata  input  32  MMIO bus read data, valid when ready is high.
REQ-019 ready  input  1  MMIO bus completion from responder; may be combinational from we/re.

Function
REQ-020 SHALL implement FSM states IDLE, REQ, RSP; one transaction outstanding at most.
REQ-021 IDLE: cmd_ready=1; on cmd_valid&cmd_ready, register addr/wdata/we/re from command and enter REQ next cycle.
REQ-022 REQ: we xor re high, addr/wdata/we/re held stable every cycle; cmd_ready=0.
REQ-023 REQ: on the first cycle where ready=1, capture rdata (read) or 0 (write) into rsp_rdata, rsp_err=0, deassert we/re and enter RSP next cycle.
REQ-024 RSP: rsp_valid=1, rsp_rdata/rsp_err stable; on rsp_ready, return to IDLE next cycle.
REQ-025 Minimum latency with a combinational responder: command accepted cycle N, strobe cycle N+1, rsp_valid cycle N+2; throughput 1 transaction per 3 cycles.
REQ-026 cmd_ready SHALL be 0 in REQ and RSP; no command is accepted in the cycle rsp_ready completes a response.
REQ-027 we and re SHALL never be high simultaneously and SHALL be registered outputs, not combinational.
REQ-028 addr and wdata SHALL retain their last values outside REQ; wdata SHALL be 0 during reads.
REQ-029 Ready seen outside REQ SHALL be ignored.

Reset
REQ-030 On rst_n low: state IDLE, we=0, re=0, addr=0, wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter 0, immediately and asynchronously.
REQ-031 Reset during REQ or RSP SHALL drop the transaction without generating a response.

Configuration
REQ-032 With macro MMIO_INITIATOR_TIMEOUT_EN defined: 8-bit counter clears on REQ entry and increments each REQ cycle with ready=0; on reaching TIMEOUT_CYCLES, deassert strobes, rsp_rdata=0, rsp_err=1, enter RSP.
REQ-033 Without MMIO_INITIATOR_TIMEOUT_EN: no counter, REQ waits indefinitely for ready, rsp_err tied 0.
REQ-034 Ready arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win: normal completion, rsp_err=0.

Structure
REQ-035 Package mmio_pkg SHALL hold MMIO_ADDR_W=8, MMIO_DATA_W=32, ID_VALUE=32'hA1C0_0001, register address constants (ID at 8'h00), and the FSM state enum.
REQ-036 Timeout counter SHALL be sub-module mmio_wdog (clear, enable, expired), instantiated only under MMIO_INITIATOR_TIMEOUT_EN.

Verification
REQ-037 Read addr 8'h00 against the UART MMIO responder -> rsp_valid at N+2, rsp_rdata=32'hA1C0_0001, rsp_err=0.
REQ-038 Write addr 8'h04, wdata 32'h1234_5678 -> we high exactly one cycle with wdata 32'h1234_5678, rsp_rdata=0, rsp_err=0.
REQ-039 Responder ready held 0, timeout enabled, TIMEOUT_CYCLES=16 -> strobe high 16 cycles, then rsp_err=1, rsp_rdata=0; disabled build -> strobe held until ready.
REQ-040 rsp_ready low 5 cycles with a second command pending -> rsp fields stable, cmd_ready=0 throughout; second command accepted the cycle after rsp_ready.
REQ-041 rst_n asserted mid-REQ -> we/re fall without waiting for clk, no rsp_valid after release, next read of 8'h00 completes normally.
REQ-042 Delayed responder (ready 3 cycles after strobe) -> addr/re stable all 3 cycles, rdata sampled only on the ready cycle.
